// File: rtl/encoder42_b_if.sv
// Request/result bundle for the registered 4-to-2 priority encoder.
// Carries the four request lines in and the registered index/flags out.
// No handshake: the result is presented every cycle, one cycle after sampling.
interface encoder42_b_if;
    logic       i1;
    logic       i2;
    logic       i3;
    logic       i4;
    logic [1:0] o;
    logic       valid;
    logic       multi;

    // Requester side: drives the request lines, observes the result.
    modport master (
        output i1, i2, i3, i4,
        input  o, valid, multi
    );

    // Encoder side: samples the request lines, drives the result.
    modport slave (
        input  i1, i2, i3, i4,
        output o, valid, multi
    );
endinterface

// File: rtl/encoder42_b.sv
// Registered 4-to-2 priority encoder (i4 highest) with valid and multi-request flags.
// Latency: 1 cycle from input sample to registered outputs.
// Backpressure: none; a new result is produced on every clock edge.
module encoder42_b (
    input  logic           clk,
    input  logic           rst,
    encoder42_b_if.slave   bus
);

    logic [3:0] req;
    logic [1:0] idx_nxt;
    logic       valid_nxt;
    logic       multi_nxt;

    // Collapse the request lines into the next index and flags.
    always_comb begin
        req       = {bus.i4, bus.i3, bus.i2, bus.i1};
        idx_nxt   = 2'b00;
        valid_nxt = |req;
        // Any pair of lines high means two or more requests are pending.
        multi_nxt = (req[3] & (req[2] | req[1] | req[0])) |
                    (req[2] & (req[1] | req[0])) |
                    (req[1] & req[0]);
        // Highest asserted line wins; with nothing asserted the index
        // stays 00 and only valid tells it apart from a lone i1.
        casez (req)
            4'b1???: idx_nxt = 2'b11;
            4'b01??: idx_nxt = 2'b10;
            4'b001?: idx_nxt = 2'b01;
            default: idx_nxt = 2'b00;
        endcase
    end

    // Output registers; reset overrides whatever is on the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.o     <= 2'b00;
            bus.valid <= 1'b0;
            bus.multi <= 1'b0;
        end else begin
            bus.o     <= idx_nxt;
            bus.valid <= valid_nxt;
            bus.multi <= multi_nxt;
        end
    end

endmodule

// File: tb/tb_encoder42_b.sv
// Self-checking bench for encoder42_b.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Expected values come from a behavioural model (highest set bit, population count).
module tb_encoder42_b;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    encoder42_b_if bus();

    encoder42_b dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: {index, valid, multi} for a request vector {i4,i3,i2,i1}.
    function automatic logic [3:0] ref_model(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'b00;
        for (int k = 0; k < 4; k++)
            if (v[k]) idx = k[1:0];
        return {idx, (v != 4'b0000), ($countones(v) >= 2)};
    endfunction

    task automatic drive(input logic [3:0] v);
        bus.i1 = v[0];
        bus.i2 = v[1];
        bus.i3 = v[2];
        bus.i4 = v[3];
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] observed();
        return {bus.o, bus.valid, bus.multi};
    endfunction

    task automatic test_reset();
        logic [3:0] obs;
        @(negedge clk);
        rst = 1'b1;
        drive(4'b1111);
        tick();
        obs = observed();
        checks++;
        if (obs !== 4'b0000) begin
            failures++;
            $display("FAIL reset_hold got o/valid/multi=%b required=%b", obs, 4'b0000);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        obs = observed();
        checks++;
        if (obs !== 4'b1111) begin
            failures++;
            $display("FAIL reset_release got o/valid/multi=%b required=%b", obs, 4'b1111);
        end
    endtask

    task automatic test_one_hot();
        logic [3:0] obs;
        logic [3:0] exp;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(4'b0001 << k);
            tick();
            obs = observed();
            exp = {k[1:0], 1'b1, 1'b0};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL one_hot[%0d] got o/valid/multi=%b required=%b", k, obs, exp);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [3:0] obs;
        logic [3:0] exp;
        logic [3:0] vec;
        logic [3:0] lit;
        logic       has_lit;
        for (int n = 0; n < 16; n++) begin
            vec = n[3:0];
            @(negedge clk);
            drive(vec);
            tick();
            obs = observed();
            exp = ref_model(vec);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL exhaustive[%b] got o/valid/multi=%b required=%b", vec, obs, exp);
            end
            // Hand-written expectations for the named corner cases.
            has_lit = 1'b1;
            case (vec)
                4'b0000: lit = 4'b0000;
                4'b0011: lit = 4'b0111;
                4'b0101: lit = 4'b1011;
                4'b0110: lit = 4'b1011;
                4'b1001: lit = 4'b1111;
                4'b1111: lit = 4'b1111;
                default: begin lit = 4'b0000; has_lit = 1'b0; end
            endcase
            if (has_lit) begin
                checks++;
                if (obs !== lit) begin
                    failures++;
                    $display("FAIL corner[%b] got o/valid/multi=%b required=%b", vec, obs, lit);
                end
            end
        end
    endtask

    task automatic test_latency();
        logic [3:0] obs;
        @(negedge clk);
        drive(4'b0000);
        tick();
        @(negedge clk);
        drive(4'b0100);
        #1;
        obs = observed();
        checks++;
        if (obs !== 4'b0000) begin
            failures++;
            $display("FAIL latency_between_edges got o/valid/multi=%b required=%b", obs, 4'b0000);
        end
        tick();
        obs = observed();
        checks++;
        if (obs !== 4'b1010) begin
            failures++;
            $display("FAIL latency_after_edge got o/valid/multi=%b required=%b", obs, 4'b1010);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] obs;
        @(negedge clk);
        drive(4'b1000);
        tick();
        obs = observed();
        checks++;
        if (obs !== 4'b1110) begin
            failures++;
            $display("FAIL mid_reset_pre got o/valid/multi=%b required=%b", obs, 4'b1110);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        obs = observed();
        checks++;
        if (obs !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset_clear got o/valid/multi=%b required=%b", obs, 4'b0000);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        obs = observed();
        checks++;
        if (obs !== 4'b1110) begin
            failures++;
            $display("FAIL mid_reset_resume got o/valid/multi=%b required=%b", obs, 4'b1110);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] obs;
        logic [3:0] exp;
        logic [3:0] vec;
        logic       r;
        for (int n = 0; n < 300; n++) begin
            vec = 4'($urandom_range(0, 15));
            r   = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            drive(vec);
            rst = r;
            tick();
            obs = observed();
            exp = r ? 4'b0000 : ref_model(vec);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL random[%0d] vec=%b rst=%b got o/valid/multi=%b required=%b",
                         n, vec, r, obs, exp);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive(4'b0000);
        test_reset();
        test_one_hot();
        test_exhaustive();
        test_latency();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
